// File: rtl/lsu_pkg.sv
// lsu_pkg: memory op encoding, FSM states and access-size helpers for the load/store unit.
package lsu_pkg;
  typedef enum logic [3:0] {
    LB = 4'd0, LBU = 4'd1, LH = 4'd2, LHU = 4'd3, LW = 4'd4, LWL = 4'd5, LWR = 4'd6,
    SB = 4'd8, SH = 4'd9, SW = 4'd10
  } mem_op_t;
  typedef enum logic [2:0] {S_IDLE, S_ERR, S_READ, S_WRITE, S_DONE} lsu_state_t;
  function automatic logic op_valid(logic [3:0] op);
    return op inside {LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW};
  endfunction
  // LWL/LWR stay inside the aligned word, so only the addressed byte needs range checking
  function automatic logic [2:0] op_size(logic [3:0] op);
    return (op inside {LH, LHU, SH}) ? 3'd2 : (op inside {LW, SW}) ? 3'd4 : 3'd1;
  endfunction
  function automatic logic is_store(logic [3:0] op);
    return op inside {SB, SH, SW};
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: CPU request/response and data-memory port bundle of the load/store unit.
interface load_store_unit_if #(parameter int ADDR_W = 32) ();
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_store_data;
  logic [31:0]       req_rt_old;
  logic              resp_valid;
  logic [31:0]       resp_load_data;
  logic              resp_error;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic              mem_clock_enable;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;
  modport slave (
    input  req_valid, req_op, req_addr, req_store_data, req_rt_old, mem_read_data,
    output req_ready, resp_valid, resp_load_data, resp_error,
           mem_address, mem_read, mem_write, mem_clock_enable, mem_write_data
  );
  modport master (
    output req_valid, req_op, req_addr, req_store_data, req_rt_old, mem_read_data,
    input  req_ready, resp_valid, resp_load_data, resp_error,
           mem_address, mem_read, mem_write, mem_clock_enable, mem_write_data
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: big-endian byte steering; load extract/extend, LWL/LWR merge and sub-word store merge.
module lsu_byte_lane import lsu_pkg::*; (
  input  mem_op_t     op_i,
  input  logic [1:0]  k_i,
  input  logic [31:0] word_i,
  input  logic [31:0] rt_old_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);
  logic [4:0]  ls, rs, hs;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    ls = {k_i, 3'b000};
    rs = {~k_i, 3'b000};
    hs = {~k_i[1], 4'b0000};
    b = 8'(word_i >> rs);
    h = 16'(word_i >> hs);
    load_data_o = '0;
    store_word_o = word_i;
    case (op_i)
      LB:  load_data_o = {{24{b[7]}}, b};
      LBU: load_data_o = {24'b0, b};
      LH:  load_data_o = {{16{h[15]}}, h};
      LHU: load_data_o = {16'b0, h};
      LW:  load_data_o = word_i;
      LWL: load_data_o = (word_i << ls) | (rt_old_i & ~(32'hFFFF_FFFF << ls));
      LWR: load_data_o = (word_i >> rs) | (rt_old_i & ~(32'hFFFF_FFFF >> rs));
      SB:  store_word_o = (word_i & ~(32'hFF << rs)) | ({24'b0, store_data_i[7:0]} << rs);
      SH:  store_word_o = (word_i & ~(32'hFFFF << hs)) | ({16'b0, store_data_i[15:0]} << hs);
      SW:  store_word_o = store_data_i;
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MIPS load/store sequencer onto a word-wide big-endian data memory.
module load_store_unit import lsu_pkg::*; #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input logic clk,
  input logic reset,
  load_store_unit_if.slave bus
);
  lsu_state_t        state_q, state_d;
  mem_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d, rt_q, rt_d, word_q, word_d, load_q, load_d;
  logic [31:0]       lane_load, lane_store;
  logic [ADDR_W:0]   last;
  logic [2:0]        sz;
  logic              req_err, rd, wr;
  always_comb begin
    sz = op_size(bus.req_op);
    last = {1'b0, bus.req_addr} + (ADDR_W+1)'(sz - 3'd1);
    req_err = !op_valid(bus.req_op) || (sz == 3'd2 && bus.req_addr[0]) ||
              (sz == 3'd4 && bus.req_addr[1:0] != 2'b00) || last >= (ADDR_W+1)'(MEM_BYTES);
  end
  // during READ the lane sees live memory data so loads resolve without an extra cycle
  lsu_byte_lane u_lane (
    .op_i(op_q), .k_i(addr_q[1:0]),
    .word_i(state_q == S_READ ? bus.mem_read_data : word_q),
    .rt_old_i(rt_q), .store_data_i(data_q),
    .load_data_o(lane_load), .store_word_o(lane_store)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    data_d = data_q;
    rt_d = rt_q;
    word_d = word_q;
    load_d = load_q;
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        op_d = mem_op_t'(bus.req_op);
        addr_d = bus.req_addr;
        data_d = bus.req_store_data;
        rt_d = bus.req_rt_old;
        state_d = req_err ? S_ERR : (bus.req_op == SW) ? S_WRITE : S_READ;
        load_d = req_err ? '0 : load_q;
      end
      S_ERR: state_d = S_IDLE;
      S_READ: begin
        word_d = bus.mem_read_data;
        state_d = is_store(op_q) ? S_WRITE : S_DONE;
        load_d = is_store(op_q) ? load_q : lane_load;
      end
      S_WRITE: begin
        state_d = S_DONE;
        load_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q <= LB;
      addr_q <= '0;
      data_q <= '0;
      rt_q <= '0;
      word_q <= '0;
      load_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rt_q <= rt_d;
      word_q <= word_d;
      load_q <= load_d;
    end
  end
  assign rd = state_q == S_READ;
  assign wr = state_q == S_WRITE && reset;
  assign bus.req_ready = state_q == S_IDLE;
  assign bus.resp_valid = state_q == S_ERR || state_q == S_DONE;
  assign bus.resp_error = state_q == S_ERR;
  assign bus.resp_load_data = load_q;
  assign bus.mem_address = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_read = rd;
  assign bus.mem_write = wr;
  assign bus.mem_clock_enable = rd || wr;
  assign bus.mem_write_data = state_q == S_WRITE ? lane_store : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random load/store traffic checked against a byte-array reference memory.
module tb_load_store_unit;
  logic clk = 0;
  logic reset = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] mem [0:4095];
  logic [7:0] ref_mem [0:4095];
  logic [11:0] ma;
  logic [31:0] d;
  load_store_unit_if #(.ADDR_W(32)) bus ();
  load_store_unit #(.ADDR_W(32), .MEM_BYTES(4096)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign ma = bus.mem_address[11:0];
  assign bus.mem_read_data = {mem[ma], mem[ma+12'd1], mem[ma+12'd2], mem[ma+12'd3]};
  always @(posedge clk)
    if (bus.mem_write) begin
      mem[ma] <= bus.mem_write_data[31:24];
      mem[ma+12'd1] <= bus.mem_write_data[23:16];
      mem[ma+12'd2] <= bus.mem_write_data[15:8];
      mem[ma+12'd3] <= bus.mem_write_data[7:0];
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int w);
    return {mem[w], mem[w+1], mem[w+2], mem[w+3]};
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[w], ref_mem[w+1], ref_mem[w+2], ref_mem[w+3]};
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rt, output logic [31:0] obs);
    int sz, lat, xr, xw, cyc, nr, nw, k;
    logic e, got, gerr;
    logic [31:0] xd;
    sz = (op == 2 || op == 3 || op == 9) ? 2 : (op == 4 || op == 10) ? 4 : 1;
    e = !(op <= 6 || (op >= 8 && op <= 10)) || (a % sz != 0) || ({32'b0, a} + 64'(sz) - 64'd1 >= 64'd4096);
    lat = e ? 1 : (op == 8 || op == 9) ? 3 : 2;
    xr = (!e && op != 10) ? 1 : 0;
    xw = (!e && op >= 8) ? 1 : 0;
    xd = '0;
    k = int'(a % 4);
    if (!e)
      case (op)
        0: xd = {{24{ref_mem[a][7]}}, ref_mem[a]};
        1: xd = {24'b0, ref_mem[a]};
        2: xd = {{16{ref_mem[a][7]}}, ref_mem[a], ref_mem[a+1]};
        3: xd = {16'b0, ref_mem[a], ref_mem[a+1]};
        4: xd = ref_word(int'(a));
        5: begin xd = rt; for (int j = 0; j < 4 - k; j++) xd[31-8*j -: 8] = ref_mem[a+j]; end
        6: begin xd = rt; for (int j = 0; j <= k; j++) xd[8*j +: 8] = ref_mem[a-j]; end
        8: ref_mem[a] = sd[7:0];
        9: begin ref_mem[a] = sd[15:8]; ref_mem[a+1] = sd[7:0]; end
        10: for (int j = 0; j < 4; j++) ref_mem[a+j] = sd[31-8*j -: 8];
        default: ;
      endcase
    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid = 1;
    bus.req_op = op;
    bus.req_addr = a;
    bus.req_store_data = sd;
    bus.req_rt_old = rt;
    @(posedge clk);
    #1;
    bus.req_valid = 0;
    bus.req_op = 4'($urandom);
    bus.req_addr = $urandom;
    bus.req_store_data = $urandom;
    bus.req_rt_old = $urandom;
    cyc = 0; nr = 0; nw = 0; got = 0; gerr = 0; obs = 'x;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      nr += int'(bus.mem_read);
      nw += int'(bus.mem_write);
      if (bus.resp_valid) begin
        got = 1;
        gerr = bus.resp_error;
        obs = bus.resp_load_data;
      end
    end
    check("latency", cyc, lat);
    check("resp_error", 32'(gerr), 32'(e));
    check("load_data", obs, xd);
    check("mem_read_cycles", nr, xr);
    check("mem_write_cycles", nw, xw);
    @(negedge clk);
    check("resp_pulse", 32'(bus.resp_valid), 0);
    check("load_hold", bus.resp_load_data, xd);
    if (xw == 1) check("store_word", mem_word(int'(a & ~32'd3)), ref_word(int'(a & ~32'd3)));
  endtask

  initial begin
    int bad, r;
    logic [31:0] a;
    bus.req_valid = 0;
    bus.req_op = 0;
    bus.req_addr = 0;
    bus.req_store_data = 0;
    bus.req_rt_old = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      mem[i] = 8'hFF; mem[4+i] = 8'h55; mem[8+i] = 8'h01; mem[12+i] = 8'hCC;
    end
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 1);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_error", 32'(bus.resp_error), 0);
    check("rst_load_data", bus.resp_load_data, 0);
    check("rst_mem_strobes", {29'b0, bus.mem_read, bus.mem_write, bus.mem_clock_enable}, 0);
    check("rst_mem_address", bus.mem_address, 0);
    check("rst_mem_wdata", bus.mem_write_data, 0);
    reset = 1;
    do_op(4, 32'h4, 0, 0, d);          check("lw_4", d, 32'h5555_5555);
    do_op(0, 32'h0, 0, 0, d);          check("lb_0", d, 32'hFFFF_FFFF);
    do_op(1, 32'h0, 0, 0, d);          check("lbu_0", d, 32'h0000_00FF);
    do_op(2, 32'hA, 0, 0, d);          check("lh_a", d, 32'h0000_0101);
    do_op(8, 32'hD, 32'hAB, 0, d);     check("sb_d_mem", mem_word(12), 32'hCCAB_CCCC);
    do_op(4, 32'hC, 0, 0, d);          check("lw_c", d, 32'hCCAB_CCCC);
    do_op(2, 32'h5, 0, 0, d);          check("lh_5_err_data", d, 0);
    do_op(10, 32'h2, 32'h1234_5678, 0, d);
    do_op(4, 32'hFFE, 0, 0, d);
    do_op(5, 32'h9, 0, 32'h1122_3344, d); check("lwl_9", d, 32'h0101_0144);
    do_op(6, 32'h9, 0, 32'h1122_3344, d); check("lwr_9", d, 32'h1122_0101);
    do_op(4'd7, 32'h10, 0, 0, d);
    do_op(4, 32'hFFC, 0, 0, d);
    do_op(4, 32'h1000, 0, 0, d);
    // reset asserted during the write cycle of an SH must suppress the write and any response
    @(negedge clk);
    bus.req_valid = 1; bus.req_op = 4'd9; bus.req_addr = 32'h4; bus.req_store_data = 32'hBEEF;
    @(posedge clk);
    #1 bus.req_valid = 0;
    @(negedge clk);
    check("sh_rst_read", 32'(bus.mem_read), 1);
    @(negedge clk);
    reset = 0;
    #1;
    check("sh_rst_mem_write", 32'(bus.mem_write), 0);
    check("sh_rst_clock_en", 32'(bus.mem_clock_enable), 0);
    @(negedge clk);
    check("sh_rst_ready", 32'(bus.req_ready), 1);
    check("sh_rst_no_resp", 32'(bus.resp_valid), 0);
    check("sh_rst_load_clr", bus.resp_load_data, 0);
    reset = 1;
    @(negedge clk);
    check("sh_rst_no_resp2", 32'(bus.resp_valid), 0);
    check("sh_rst_word", mem_word(4), 32'h5555_5555);
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 3));
      a = (r == 0) ? 32'(4088 + $urandom_range(0, 15)) : (r == 1) ? $urandom : 32'($urandom_range(0, 4095));
      do_op(4'($urandom_range(0, 15)), a, $urandom, $urandom, d);
    end
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_final", bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
